// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite transfer types, response codes and slave FSM states
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    localparam logic       HRESP_OKAY  = 1'b0;
    localparam logic       HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } slave_state_t;

endpackage

// File: rtl/ahb_imem_slave.sv
// rtl/ahb_imem_slave.sv - AHB-Lite word memory slave with wait states and two-cycle error response
module ahb_imem_slave
    import ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'hA000_0000,
    parameter int          DEPTH       = 16,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
    localparam logic [31:0] WINDOW_BYTES = 32'(4 * DEPTH);

    slave_state_t     state;
    slave_state_t     state_next;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx_q;
    logic             wr_q;
    logic [31:0]      mem [DEPTH];

    htrans_t          trans;
    logic [31:0]      offset;
    logic             in_window;
    logic             addr_err;
    logic             can_accept;
    logic             accept;

    // Subtracting first makes addresses below the base wrap to huge offsets,
    // so a single unsigned compare rejects both sides of the window.
    assign trans      = htrans_t'(htrans);
    assign offset     = haddr - BASE_ADDR;
    assign in_window  = offset < WINDOW_BYTES;
    assign addr_err   = !in_window || (haddr[1:0] != 2'b00) || (hsize != HSIZE_WORD);
    assign can_accept = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR2);
    assign accept     = can_accept && hsel && hready &&
                        ((trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: ready states may take a new address phase, WAIT counts down, errors last two cycles
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                if (accept) begin
                    if (addr_err) begin
                        state_next = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_next = ST_WAIT;
                    end else begin
                        state_next = ST_DONE;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt == CNT_LAST) begin
                    state_next = ST_DONE;
                end
            end
            ST_ERR1: state_next = ST_ERR2;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output decode: stall in WAIT/ERR1, flag ERROR in both error cycles, read data only in a read DONE
    always_comb begin
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        hrdata    = '0;
        unique case (state)
            ST_WAIT: hreadyout = 1'b0;
            ST_DONE: begin
                if (!wr_q) begin
                    hrdata = mem[idx_q];
                end
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
            end
            ST_ERR2: hresp = HRESP_ERROR;
            default: ;
        endcase
    end

    // Capture word index and direction of each accepted address phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
            wr_q  <= 1'b0;
        end else if (accept) begin
            idx_q <= offset[IDX_W+1:2];
            wr_q  <= hwrite;
        end
    end

    // Wait-state counter: runs only while in WAIT, rewinds on the exit cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == ST_WAIT) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        end else begin
            cnt <= '0;
        end
    end

    // Word array: cleared by reset, written at the closing edge of a write DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if ((state == ST_DONE) && wr_q) begin
            mem[idx_q] <= hwdata;
        end
    end

endmodule

// File: tb/tb_ahb_imem_slave.sv
// tb/tb_ahb_imem_slave.sv - table-driven scoreboard bench for ahb_imem_slave
module tb_ahb_imem_slave;
    import ahb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsel;
    logic        use0;
    logic        block;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;

    logic        hsel_a, hready_a, hreadyout_a, hresp_a;
    logic [31:0] hrdata_a;
    logic        hsel_b, hready_b, hreadyout_b, hresp_b;
    logic [31:0] hrdata_b;
    logic        obs_rdy, obs_resp;
    logic [31:0] obs_rdata;

    always #5 clk = ~clk;

    assign hsel_a    = hsel & ~use0;
    assign hsel_b    = hsel & use0;
    assign hready_a  = hreadyout_a & ~block;
    assign hready_b  = hreadyout_b & ~block;
    assign obs_rdy   = use0 ? hreadyout_b : hreadyout_a;
    assign obs_resp  = use0 ? hresp_b     : hresp_a;
    assign obs_rdata = use0 ? hrdata_b    : hrdata_a;

    ahb_imem_slave #(.BASE_ADDR(32'hA000_0000), .DEPTH(16), .WAIT_STATES(1)) dut (
        .clk(clk), .reset(reset), .hsel(hsel_a), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hready(hready_a), .hwdata(hwdata),
        .hreadyout(hreadyout_a), .hresp(hresp_a), .hrdata(hrdata_a)
    );

    ahb_imem_slave #(.BASE_ADDR(32'hA000_0000), .DEPTH(16), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .hsel(hsel_b), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hready(hready_b), .hwdata(hwdata),
        .hreadyout(hreadyout_b), .hresp(hresp_b), .hrdata(hrdata_b)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        resp;
        logic [31:0] rdata;
        int          cycles;
    } exp_t;

    vec_t req_q[$];
    exp_t sb_q[$];
    int   done_iter_q[$];
    int   checks = 0;
    int   fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                                input logic [31:0] wdata, input logic exp_resp, input logic [31:0] exp_rdata);
        vec_t v;
        v.addr = addr; v.wr = wr; v.size = size; v.wdata = wdata;
        v.exp_resp = exp_resp; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic bus_idle();
        hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hsize = HSIZE_WORD;
    endtask

    // Drives queued transfers pipelined; entered and left just after a rising edge
    task automatic run_bus(input int ws);
        logic        dp_active = 1'b0;
        logic [31:0] dp_wdata  = '0;
        int          dp_cycles = 0;
        int          iter      = 0;
        logic        addr_on, rdy_s, done_now;
        exp_t        e;
        done_iter_q.delete();
        while ((req_q.size() > 0 || dp_active) && iter < 100) begin
            addr_on = (req_q.size() > 0);
            if (addr_on) begin
                hsel = 1'b1; haddr = req_q[0].addr; htrans = 2'b10;
                hwrite = req_q[0].wr; hsize = req_q[0].size;
            end else begin
                bus_idle();
            end
            hwdata = dp_active ? dp_wdata : 32'h0;
            @(negedge clk);
            rdy_s    = obs_rdy;
            done_now = 1'b0;
            if (dp_active) begin
                dp_cycles++;
                if (obs_rdy) begin
                    e = sb_q.pop_front();
                    check("final_hresp", 32'(obs_resp), 32'(e.resp));
                    check("final_hrdata", obs_rdata, e.rdata);
                    check("phase_cycles", dp_cycles, e.cycles);
                    done_iter_q.push_back(iter);
                    done_now = 1'b1;
                end else begin
                    check("stall_hresp", 32'(obs_resp), 32'(sb_q[0].resp));
                    check("stall_hrdata", obs_rdata, 32'h0);
                end
            end else begin
                check("idle_hreadyout", 32'(obs_rdy), 32'h1);
            end
            @(posedge clk);
            #1;
            if (done_now) dp_active = 1'b0;
            if (addr_on && rdy_s) begin
                e.resp   = req_q[0].exp_resp;
                e.rdata  = req_q[0].exp_resp ? 32'h0 : req_q[0].exp_rdata;
                e.cycles = e.resp ? 2 : ws + 1;
                sb_q.push_back(e);
                dp_wdata  = req_q[0].wdata;
                dp_active = 1'b1;
                dp_cycles = 0;
                void'(req_q.pop_front());
            end
            iter++;
        end
        if (iter >= 100) begin
            check("bus_timeout", 32'(iter), 32'h0);
            req_q.delete();
            sb_q.delete();
        end
        bus_idle();
        hwdata = '0;
    endtask

    initial begin
        vec_t tbl[12];
        vec_t tbl0[3];

        bus_idle();
        hwdata = '0; use0 = 1'b0; block = 1'b0; reset = 1'b1;

        tbl[0]  = mk(32'hA000_0004, 1'b1, HSIZE_WORD, 32'hDEAD_BEEF, 1'b0, 32'h0);
        tbl[1]  = mk(32'hA000_0004, 1'b0, HSIZE_WORD, 32'h0,         1'b0, 32'hDEAD_BEEF);
        tbl[2]  = mk(32'hA000_0040, 1'b0, HSIZE_WORD, 32'h0,         1'b1, 32'h0);
        tbl[3]  = mk(32'h9FFF_FFFC, 1'b0, HSIZE_WORD, 32'h0,         1'b1, 32'h0);
        tbl[4]  = mk(32'hA000_0002, 1'b0, HSIZE_WORD, 32'h0,         1'b1, 32'h0);
        tbl[5]  = mk(32'hA000_0004, 1'b0, 3'b000,     32'h0,         1'b1, 32'h0);
        tbl[6]  = mk(32'hA000_0004, 1'b1, 3'b000,     32'h1234_5678, 1'b1, 32'h0);
        tbl[7]  = mk(32'hA000_0004, 1'b0, HSIZE_WORD, 32'h0,         1'b0, 32'hDEAD_BEEF);
        tbl[8]  = mk(32'hA000_0000, 1'b1, HSIZE_WORD, 32'h1111_1111, 1'b0, 32'h0);
        tbl[9]  = mk(32'hA000_0004, 1'b1, HSIZE_WORD, 32'h2222_2222, 1'b0, 32'h0);
        tbl[10] = mk(32'hA000_003C, 1'b1, HSIZE_WORD, 32'hCAFE_F00D, 1'b0, 32'h0);
        tbl[11] = mk(32'hA000_003C, 1'b0, HSIZE_WORD, 32'h0,         1'b0, 32'hCAFE_F00D);

        tbl0[0] = mk(32'hA000_003C, 1'b1, HSIZE_WORD, 32'h0BAD_F00D, 1'b0, 32'h0);
        tbl0[1] = mk(32'hA000_003C, 1'b0, HSIZE_WORD, 32'h0,         1'b0, 32'h0BAD_F00D);
        tbl0[2] = mk(32'hA000_0040, 1'b0, HSIZE_WORD, 32'h0,         1'b1, 32'h0);

        repeat (2) @(negedge clk);
        check("rst_hreadyout", 32'(obs_rdy), 32'h1);
        check("rst_hresp", 32'(obs_resp), 32'h0);
        check("rst_hrdata", obs_rdata, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 12; i++) req_q.push_back(tbl[i]);
        run_bus(1);

        req_q.push_back(mk(32'hA000_0000, 1'b0, HSIZE_WORD, 32'h0, 1'b0, 32'h1111_1111));
        req_q.push_back(mk(32'hA000_0004, 1'b0, HSIZE_WORD, 32'h0, 1'b0, 32'h2222_2222));
        run_bus(1);
        check("pipe_completions", 32'(done_iter_q.size()), 32'h2);
        check("pipe_first_done", 32'(done_iter_q[0]), 32'h2);
        check("pipe_second_done", 32'(done_iter_q[1]), 32'h4);

        // Address phase while another slave holds HREADY low must be ignored
        block = 1'b1; hsel = 1'b1; haddr = 32'hA000_0008; htrans = 2'b10;
        hwrite = 1'b1; hsize = HSIZE_WORD;
        @(negedge clk);
        check("blocked_hreadyout", 32'(obs_rdy), 32'h1);
        @(posedge clk);
        #1;
        block = 1'b0; bus_idle(); hwdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("blocked_no_phase_rdy", 32'(obs_rdy), 32'h1);
        check("blocked_no_phase_resp", 32'(obs_resp), 32'h0);
        @(posedge clk);
        #1 hwdata = '0;
        req_q.push_back(mk(32'hA000_0008, 1'b0, HSIZE_WORD, 32'h0, 1'b0, 32'h0));
        run_bus(1);

        // Reset asserted in the WAIT cycle of a write to word 4
        hsel = 1'b1; haddr = 32'hA000_0010; htrans = 2'b10; hwrite = 1'b1; hsize = HSIZE_WORD;
        @(posedge clk);
        #1;
        bus_idle(); hwdata = 32'h5A5A_5A5A;
        @(negedge clk);
        check("wr_wait_hreadyout", 32'(obs_rdy), 32'h0);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_hreadyout", 32'(obs_rdy), 32'h1);
        check("mid_rst_hresp", 32'(obs_resp), 32'h0);
        check("mid_rst_hrdata", obs_rdata, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0; hwdata = '0;
        @(negedge clk);
        check("post_rst_hreadyout", 32'(obs_rdy), 32'h1);
        @(posedge clk);
        #1;
        req_q.push_back(mk(32'hA000_0010, 1'b0, HSIZE_WORD, 32'h0, 1'b0, 32'h0));
        req_q.push_back(mk(32'hA000_0008, 1'b0, HSIZE_WORD, 32'h0, 1'b0, 32'h0));
        req_q.push_back(mk(32'hA000_0004, 1'b0, HSIZE_WORD, 32'h0, 1'b0, 32'h0));
        run_bus(1);

        use0 = 1'b1;
        for (int i = 0; i < 3; i++) req_q.push_back(tbl0[i]);
        run_bus(0);
        check("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
